// File: rtl/amm_burst_splitter.sv
// amm_burst_splitter
// Turns each upstream Avalon-MM read or write burst into a run of single-beat
// transfers with incrementing byte addresses. This feeds a CDC bridge that
// only handles single beats. Read responses pass straight through, with no
// outstanding-read tracking. DATA_W must be a power of two and at least 8.
// The maximum burst length is 2^(BURST_W-1).
module amm_burst_splitter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // upstream side (this block is the slave)
    input  logic [ADDR_W-1:0]     m_address_i,
    input  logic [BURST_W-1:0]    m_burstcount_i,
    input  logic                  m_read_i,
    input  logic                  m_write_i,
    input  logic [DATA_W-1:0]     m_writedata_i,
    input  logic [DATA_W/8-1:0]   m_byteenable_i,
    output logic                  m_waitrequest_o,
    output logic [DATA_W-1:0]     m_readdata_o,
    output logic                  m_readdatavalid_o,
    // downstream side (this block is the master, feeding the CDC bridge)
    output logic [ADDR_W-1:0]     s_address_o,
    output logic                  s_read_o,
    output logic                  s_write_o,
    output logic [DATA_W-1:0]     s_writedata_o,
    output logic [DATA_W/8-1:0]   s_byteenable_o,
    input  logic                  s_waitrequest_i,
    input  logic [DATA_W-1:0]     s_readdata_i,
    input  logic                  s_readdatavalid_i
);

    localparam int                BE_W  = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [BURST_W-1:0]   cnt_q;
    logic [BE_W-1:0]      be_q;

    logic [BURST_W-1:0]   burst_len_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [BURST_W-1:0]   cnt_d;
    logic                 beat_fire;
    logic                 last_beat;

    // Read responses are never delayed or reordered, even during reset
    assign m_readdata_o      = s_readdata_i;
    assign m_readdatavalid_o = s_readdatavalid_i;

    // Burst bookkeeping: a zero burstcount still moves one beat
    always_comb begin
        burst_len_d = (m_burstcount_i == '0) ? BURST_W'(1) : m_burstcount_i;
        addr_d      = addr_q + BYTES;
        cnt_d       = cnt_q - BURST_W'(1);
        last_beat   = (cnt_q == BURST_W'(1));
        beat_fire   = !s_waitrequest_i &&
                      ((state_q == RD_BURST) ||
                       ((state_q == WR_BURST) && m_write_i));
    end

    // Handshake and datapath steering; reset forces the bus idle at once
    always_comb begin
        s_address_o     = addr_q;
        s_writedata_o   = m_writedata_i;
        s_byteenable_o  = be_q;
        s_read_o        = 1'b0;
        s_write_o       = 1'b0;
        m_waitrequest_o = 1'b1;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    // Writes are held one cycle so the first data beat is not
                    // consumed before the burst address has been latched
                    m_waitrequest_o = !(m_read_i && !m_write_i);
                end
                RD_BURST: begin
                    s_read_o = 1'b1;
                end
                WR_BURST: begin
                    s_write_o       = m_write_i;
                    s_byteenable_o  = m_byteenable_i;
                    // A stray read during a write burst must not look accepted
                    m_waitrequest_o = s_waitrequest_i || (m_read_i && !m_write_i);
                end
                default: begin
                    m_waitrequest_o = 1'b1;
                end
            endcase
        end
    end

    // Burst FSM: latch the command in IDLE, then step address/count per beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_write_i) begin
                        addr_q  <= m_address_i;
                        cnt_q   <= burst_len_d;
                        state_q <= WR_BURST;
                    end else if (m_read_i) begin
                        addr_q  <= m_address_i;
                        cnt_q   <= burst_len_d;
                        be_q    <= m_byteenable_i;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (beat_fire) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_d;
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amm_burst_splitter.sv
// Bench for amm_burst_splitter: a scoreboard of expected downstream beats,
// filled as bursts are driven and drained by a negedge monitor.
module tb_amm_burst_splitter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m_address_i;
    logic [7:0]  m_burstcount_i;
    logic        m_read_i;
    logic        m_write_i;
    logic [63:0] m_writedata_i;
    logic [7:0]  m_byteenable_i;
    logic        m_waitrequest_o;
    logic [63:0] m_readdata_o;
    logic        m_readdatavalid_o;
    logic [31:0] s_address_o;
    logic        s_read_o;
    logic        s_write_o;
    logic [63:0] s_writedata_o;
    logic [7:0]  s_byteenable_o;
    logic        s_waitrequest_i;
    logic [63:0] s_readdata_i;
    logic        s_readdatavalid_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [63:0] data;
        logic [7:0]  be;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    vectors     = 0;
    int    miscompares = 0;

    amm_burst_splitter #(.ADDR_W(32), .DATA_W(64), .BURST_W(8)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .m_address_i       (m_address_i),
        .m_burstcount_i    (m_burstcount_i),
        .m_read_i          (m_read_i),
        .m_write_i         (m_write_i),
        .m_writedata_i     (m_writedata_i),
        .m_byteenable_i    (m_byteenable_i),
        .m_waitrequest_o   (m_waitrequest_o),
        .m_readdata_o      (m_readdata_o),
        .m_readdatavalid_o (m_readdatavalid_o),
        .s_address_o       (s_address_o),
        .s_read_o          (s_read_o),
        .s_write_o         (s_write_o),
        .s_writedata_o     (s_writedata_o),
        .s_byteenable_o    (s_byteenable_o),
        .s_waitrequest_i   (s_waitrequest_i),
        .s_readdata_i      (s_readdata_i),
        .s_readdatavalid_i (s_readdatavalid_i)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every issued downstream beat must match the head of the scoreboard
    always @(negedge clk_i) begin
        if (s_read_o && s_write_o) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_wr_overlap: s_read=%b s_write=%b, required not both high", s_read_o, s_write_o);
        end
        if ((s_read_o || s_write_o) && !s_waitrequest_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: addr=%h we=%b, required no beat", s_address_o, s_write_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (s_address_o !== mon_e.addr || s_write_o !== mon_e.we || s_byteenable_o !== mon_e.be ||
                    (mon_e.we && s_writedata_o !== mon_e.data)) begin
                    miscompares++;
                    $display("FAIL beat: got addr=%h we=%b be=%h data=%h, required addr=%h we=%b be=%h data=%h",
                             s_address_o, s_write_o, s_byteenable_o, s_writedata_o,
                             mon_e.addr, mon_e.we, mon_e.be, mon_e.data);
                end else begin
                    $display("beat addr=%h we=%b be=%h data=%h ok", s_address_o, s_write_o, s_byteenable_o,
                             mon_e.we ? s_writedata_o : 64'h0);
                end
            end
        end
        if (s_readdatavalid_i || m_readdatavalid_o) begin
            vectors++;
            if (m_readdatavalid_o !== s_readdatavalid_i || m_readdata_o !== s_readdata_i) begin
                miscompares++;
                $display("FAIL rd_passthru: got valid=%b data=%h, required valid=%b data=%h",
                         m_readdatavalid_o, m_readdata_o, s_readdatavalid_i, s_readdata_i);
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [7:0] bc, input logic [7:0] be, input bit stall);
        int    n;
        int    k;
        bit    accepted;
        beat_t b;
        n = (bc == 0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            b.addr = addr + 32'(i * 8);
            b.we   = 1'b0;
            b.data = 64'h0;
            b.be   = be;
            exp_q.push_back(b);
        end
        @(posedge clk_i); #1;
        m_read_i = 1'b1; m_address_i = addr; m_burstcount_i = bc; m_byteenable_i = be;
        s_waitrequest_i = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        accepted = 1'b0;
        k = 0;
        while (!accepted && k < 50) begin
            @(negedge clk_i);
            if (m_waitrequest_o === 1'b0) accepted = 1'b1;
            @(posedge clk_i); #1;
            s_waitrequest_i = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            k++;
        end
        m_read_i = 1'b0;
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL rd_accept: read at %h never accepted, required acceptance", addr);
        end
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk_i); #1;
            s_waitrequest_i = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            k++;
        end
        s_waitrequest_i = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rd_drain: %0d beats missing, required 0", exp_q.size());
            exp_q.delete();
        end
        $display("read burst addr=%h bc=%0d done", addr, bc);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] bc, input logic [63:0] base,
                            input bit stall, input bit also_read);
        int    n;
        int    k;
        int    beat;
        bit    acc;
        beat_t b;
        n = (bc == 0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            b.addr = addr + 32'(i * 8);
            b.we   = 1'b1;
            b.data = base + 64'(i);
            b.be   = 8'hFF - 8'(i);
            exp_q.push_back(b);
        end
        @(posedge clk_i); #1;
        m_write_i = 1'b1; m_read_i = also_read; m_address_i = addr; m_burstcount_i = bc;
        m_writedata_i = base; m_byteenable_i = 8'hFF;
        s_waitrequest_i = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        beat = 0;
        k = 0;
        while (beat < n && k < 200) begin
            @(negedge clk_i);
            acc = (m_waitrequest_o === 1'b0);
            @(posedge clk_i); #1;
            k++;
            if (acc) begin
                beat++;
                m_writedata_i  = base + 64'(beat);
                m_byteenable_i = 8'hFF - 8'(beat);
            end
            s_waitrequest_i = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        m_write_i = 1'b0; m_read_i = 1'b0; s_waitrequest_i = 1'b0;
        vectors++;
        if (beat != n) begin
            miscompares++;
            $display("FAIL wr_accept: %0d beats accepted, required %0d", beat, n);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wr_drain: %0d beats missing, required 0", exp_q.size());
            exp_q.delete();
        end
        $display("write burst addr=%h bc=%0d done", addr, bc);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        m_read_i = 1'b1; m_write_i = 1'b1; m_address_i = 32'h0; m_burstcount_i = 8'd4;
        m_writedata_i = 64'h0; m_byteenable_i = 8'hFF;
        s_waitrequest_i = 1'b0; s_readdata_i = 64'h1234_5678_9ABC_DEF0; s_readdatavalid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        vectors++;
        if (s_read_o !== 1'b0 || s_write_o !== 1'b0 || m_waitrequest_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: s_read=%b s_write=%b m_wait=%b, required 0 0 1",
                     s_read_o, s_write_o, m_waitrequest_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; m_read_i = 1'b0; m_write_i = 1'b0; s_readdatavalid_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (s_read_o !== 1'b0 || s_write_o !== 1'b0 || m_waitrequest_o !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_after_reset: s_read=%b s_write=%b m_wait=%b, required 0 0 1",
                     s_read_o, s_write_o, m_waitrequest_o);
        end
        $display("reset test done");
    endtask

    task automatic test_read_burst();
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.addr = 32'h100 + 32'(i * 8); b.we = 1'b0; b.data = 64'h0; b.be = 8'hFF;
            exp_q.push_back(b);
        end
        b.addr = 32'h180; b.we = 1'b0; b.data = 64'h0; b.be = 8'h0F;
        exp_q.push_back(b);
        @(posedge clk_i); #1;
        m_read_i = 1'b1; m_address_i = 32'h100; m_burstcount_i = 8'd4; m_byteenable_i = 8'hFF;
        s_waitrequest_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (m_waitrequest_o !== 1'b0 || s_read_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_accept_cycle: m_wait=%b s_read=%b, required 0 0", m_waitrequest_o, s_read_o);
        end
        @(posedge clk_i); #1;
        m_read_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid_i = 1'b1;
            s_readdata_i = 64'hD000_0000_0000_0000 + 64'(i);
            @(negedge clk_i);
            vectors++;
            if (s_read_o !== 1'b1 || m_waitrequest_o !== 1'b1) begin
                miscompares++;
                $display("FAIL rd_beat_cycle%0d: s_read=%b m_wait=%b, required 1 1", i, s_read_o, m_waitrequest_o);
            end
            @(posedge clk_i); #1;
        end
        // Cycle N+L+1: the next command is accepted straight away
        s_readdatavalid_i = 1'b0;
        m_read_i = 1'b1; m_address_i = 32'h180; m_burstcount_i = 8'd1; m_byteenable_i = 8'h0F;
        @(negedge clk_i);
        vectors++;
        if (s_read_o !== 1'b0 || m_waitrequest_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_turnaround: s_read=%b m_wait=%b, required 0 0", s_read_o, m_waitrequest_o);
        end
        @(posedge clk_i); #1;
        m_read_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        vectors++;
        if (s_read_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rd_end: s_read=%b pending=%0d, required 0 0", s_read_o, exp_q.size());
            exp_q.delete();
        end
        $display("read burst test done");
    endtask

    task automatic test_write_burst();
        beat_t b;
        b.we = 1'b1; b.be = 8'hFF;
        b.addr = 32'h40; b.data = 64'hAAAA_AAAA_AAAA_AAAA; exp_q.push_back(b);
        b.addr = 32'h48; b.data = 64'hBBBB_BBBB_BBBB_BBBB; exp_q.push_back(b);
        b.addr = 32'h50; b.data = 64'hCCCC_CCCC_CCCC_CCCC; exp_q.push_back(b);
        @(posedge clk_i); #1;
        m_write_i = 1'b1; m_address_i = 32'h40; m_burstcount_i = 8'd3;
        m_writedata_i = 64'hAAAA_AAAA_AAAA_AAAA; m_byteenable_i = 8'hFF; s_waitrequest_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (m_waitrequest_o !== 1'b1 || s_write_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_first_hold: m_wait=%b s_write=%b, required 1 0", m_waitrequest_o, s_write_o);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        vectors++;
        if (s_write_o !== 1'b1 || m_waitrequest_o !== 1'b0 || s_address_o !== 32'h40) begin
            miscompares++;
            $display("FAIL wr_beat_a: s_write=%b m_wait=%b addr=%h, required 1 0 00000040",
                     s_write_o, m_waitrequest_o, s_address_o);
        end
        @(posedge clk_i); #1;
        m_writedata_i = 64'hBBBB_BBBB_BBBB_BBBB; s_waitrequest_i = 1'b1;
        @(negedge clk_i);
        vectors++;
        if (s_write_o !== 1'b1 || m_waitrequest_o !== 1'b1 || s_address_o !== 32'h48) begin
            miscompares++;
            $display("FAIL wr_beat_b_stall: s_write=%b m_wait=%b addr=%h, required 1 1 00000048",
                     s_write_o, m_waitrequest_o, s_address_o);
        end
        @(posedge clk_i); #1;
        s_waitrequest_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (m_waitrequest_o !== 1'b0 || s_address_o !== 32'h48) begin
            miscompares++;
            $display("FAIL wr_beat_b: m_wait=%b addr=%h, required 0 00000048", m_waitrequest_o, s_address_o);
        end
        @(posedge clk_i); #1;
        m_writedata_i = 64'hCCCC_CCCC_CCCC_CCCC;
        @(negedge clk_i);
        vectors++;
        if (m_waitrequest_o !== 1'b0 || s_address_o !== 32'h50) begin
            miscompares++;
            $display("FAIL wr_beat_c: m_wait=%b addr=%h, required 0 00000050", m_waitrequest_o, s_address_o);
        end
        @(posedge clk_i); #1;
        m_write_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (s_write_o !== 1'b0 || m_waitrequest_o !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wr_idle: s_write=%b m_wait=%b pending=%0d, required 0 1 0",
                     s_write_o, m_waitrequest_o, exp_q.size());
            exp_q.delete();
        end
        $display("write burst test done");
    endtask

    task automatic test_write_gap();
        beat_t b;
        b.we = 1'b1;
        b.addr = 32'h200; b.data = 64'h0000_0000_0000_00D0; b.be = 8'h0F; exp_q.push_back(b);
        b.addr = 32'h208; b.data = 64'h0000_0000_0000_00D1; b.be = 8'hF0; exp_q.push_back(b);
        @(posedge clk_i); #1;
        m_write_i = 1'b1; m_address_i = 32'h200; m_burstcount_i = 8'd2;
        m_writedata_i = 64'hD0; m_byteenable_i = 8'h0F; s_waitrequest_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        vectors++;
        if (s_write_o !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_first_beat: s_write=%b, required 1", s_write_o);
        end
        @(posedge clk_i); #1;
        m_write_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            vectors++;
            if (s_write_o !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_cycle%0d: s_write=%b, required 0", i, s_write_o);
            end
            @(posedge clk_i); #1;
        end
        m_write_i = 1'b1; m_writedata_i = 64'hD1; m_byteenable_i = 8'hF0;
        @(negedge clk_i);
        vectors++;
        if (s_write_o !== 1'b1 || s_address_o !== 32'h208) begin
            miscompares++;
            $display("FAIL gap_second_beat: s_write=%b addr=%h, required 1 00000208", s_write_o, s_address_o);
        end
        @(posedge clk_i); #1;
        m_write_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (s_write_o !== 1'b0 || m_waitrequest_o !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL gap_end: s_write=%b m_wait=%b pending=%0d, required 0 1 0",
                     s_write_o, m_waitrequest_o, exp_q.size());
            exp_q.delete();
        end
        $display("write gap test done");
    endtask

    task automatic test_wrap();
        // Expected beats 0xFFFF_FFF8 then 0x0000_0000 come from do_read's modulo-2^32 model
        do_read(32'hFFFF_FFF8, 8'd2, 8'hFF, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        beat_t b;
        b.addr = 32'h300; b.we = 1'b0; b.data = 64'h0; b.be = 8'h3C;
        exp_q.push_back(b);
        @(posedge clk_i); #1;
        m_read_i = 1'b1; m_address_i = 32'h300; m_burstcount_i = 8'd4; m_byteenable_i = 8'h3C;
        s_waitrequest_i = 1'b0;
        @(posedge clk_i); #1;
        m_read_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1; m_read_i = 1'b1;
        s_readdatavalid_i = 1'b1; s_readdata_i = 64'hFEED_FACE_0000_0001;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            vectors++;
            if (s_read_o !== 1'b0 || m_waitrequest_o !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_mid%0d: s_read=%b m_wait=%b, required 0 1", i, s_read_o, m_waitrequest_o);
            end
            @(posedge clk_i); #1;
        end
        rst_i = 1'b0; m_read_i = 1'b0; s_readdatavalid_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (s_read_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_abandon: s_read=%b pending=%0d, required 0 0", s_read_o, exp_q.size());
            exp_q.delete();
        end
        do_read(32'h500, 8'd1, 8'hFF, 1'b0);
        repeat (3) @(posedge clk_i);
        $display("reset mid-burst test done");
    endtask

    task automatic test_bc0_and_rw();
        do_read(32'h600, 8'd0, 8'hA5, 1'b0);
        repeat (2) @(posedge clk_i);
        do_write(32'h700, 8'd1, 64'h7777_0000_0000_0000, 1'b0, 1'b1);
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rw_extra: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        $display("burstcount0 and read+write test done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [7:0]  bc;
        do_read(32'h1000, 8'd5, 8'hFF, 1'b1);
        do_write(32'h2000, 8'd4, 64'h2000_0000_0000_0000, 1'b1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            a  = {$urandom_range(0, 32'h0FFF_FFFF), 3'b000} ;
            bc = 8'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1)
                do_write(a, bc, {32'($urandom), 32'($urandom)}, 1'b1, 1'b0);
            else
                do_read(a, bc, 8'($urandom), 1'b1);
        end
        $display("back-to-back test done");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_burst();
        test_write_burst();
        test_write_gap();
        test_wrap();
        test_reset_mid_burst();
        test_bc0_and_rw();
        test_back_to_back();
        repeat (2) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
